// File: rtl/clksel_pkg.sv
// Shared definitions for the clock-select sequencer: FSM state encoding and
// clockgenerator sel codes.
package clksel_pkg;

    localparam int DEFAULT_CNT_W = 5;

    localparam logic [2:0] SEL_OFF   = 3'b000;
    localparam logic [2:0] SEL_DIV1  = 3'b001;
    localparam logic [2:0] SEL_DIV2  = 3'b010;
    localparam logic [2:0] SEL_DIV4  = 3'b011;
    localparam logic [2:0] SEL_DIV8  = 3'b100;
    localparam logic [2:0] SEL_DIV16 = 3'b101;
    localparam logic [2:0] SEL_DIV32 = 3'b110;
    localparam logic [2:0] SEL_HIGH  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ACK    = 3'd5
    } state_e;

endpackage

// File: rtl/clksel_arb.sv
// Fixed-priority two-requester arbiter: requester 0 wins. Grant and code are
// latched only while enabled, so they stay stable for a whole switch sequence.
module clksel_arb
    import clksel_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       req0_i,
    input  logic [2:0] code0_i,
    input  logic       req1_i,
    input  logic [2:0] code1_i,
    output logic       req_any_o,
    output logic [2:0] win_code_o,
    output logic [2:0] cur_code_o,
    output logic       grant_o
);

    logic       grant_q, grant_d;
    logic [2:0] code_q, code_d;

    assign req_any_o  = req0_i | req1_i;
    assign win_code_o = req0_i ? code0_i : code1_i;

    always_comb begin
        grant_d = grant_q;
        code_d  = code_q;
        if (en_i && req_any_o) begin
            grant_d = ~req0_i;
            code_d  = win_code_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q <= 1'b0;
            code_q  <= SEL_OFF;
        end else begin
            grant_q <= grant_d;
            code_q  <= code_d;
        end
    end

    assign cur_code_o = code_q;
    assign grant_o    = grant_q;

endmodule

// File: rtl/clksel_sequencer.sv
// Glitch-free sel switching for clockgenerator: align to divider wrap, gate, switch,
// settle, ack. Define CLKSEL_SWCNT_EN to add the saturating sw_count output.
module clksel_sequencer
    import clksel_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [2:0] RESET_SEL     = SEL_DIV1,
    parameter int         CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] code0,
    input  logic       req1,
    input  logic [2:0] code1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] sel_out,
    output logic       div_clr,
    output logic       gate_en,
    output logic       busy
`ifdef CLKSEL_SWCNT_EN
    ,
    output logic [7:0] sw_count
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [3:0]         settle_q, settle_d;
    logic [2:0]         sel_q, sel_d;
    logic               gate_q, gate_d;

    logic       req_any;
    logic [2:0] win_code;
    logic [2:0] cur_code;
    logic       grant;

    clksel_arb u_arb (
        .clk_i      (clkin),
        .rst_i      (rst),
        .en_i       (state_q == ST_IDLE),
        .req0_i     (req0),
        .code0_i    (code0),
        .req1_i     (req1),
        .code1_i    (code1),
        .req_any_o  (req_any),
        .win_code_o (win_code),
        .cur_code_o (cur_code),
        .grant_o    (grant)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + CNT_W'(1);
        settle_d = settle_q;
        sel_d    = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) state_d = (win_code == sel_q) ? ST_ACK : ST_ALIGN;
            end
            ST_ALIGN: begin
                if (&phase_q) state_d = ST_GATE;
            end
            ST_GATE: begin
                // sel is loaded here so it is already stable during SWITCH
                state_d = ST_SWITCH;
                sel_d   = cur_code;
            end
            ST_SWITCH: begin
                state_d  = ST_SETTLE;
                phase_d  = '0;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_ACK;
                else                         settle_d = settle_q + 4'd1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Gate enable is registered from the next state so the clock gate sees a clean level
        gate_d = !(state_d inside {ST_GATE, ST_SWITCH, ST_SETTLE});
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            settle_q <= '0;
            sel_q    <= RESET_SEL;
            gate_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            gate_q   <= gate_d;
        end
    end

    assign sel_out = sel_q;
    assign gate_en = gate_q;
    assign div_clr = (state_q == ST_SWITCH);
    assign ack0    = (state_q == ST_ACK) && !grant;
    assign ack1    = (state_q == ST_ACK) && grant;
    assign busy    = (state_q != ST_IDLE);

`ifdef CLKSEL_SWCNT_EN
    logic [7:0] swcnt_q, swcnt_d;

    always_comb begin
        swcnt_d = swcnt_q;
        if (state_q == ST_SWITCH && swcnt_q != 8'hFF) swcnt_d = swcnt_q + 8'd1;
    end

    always_ff @(posedge clkin) begin
        if (rst) swcnt_q <= 8'd0;
        else     swcnt_q <= swcnt_d;
    end

    assign sw_count = swcnt_q;
`endif

endmodule

// File: doc/clksel_sequencer.md
Name: clksel_sequencer

Overview:
- Controller in front of clockgenerator.
- Accepts divider-select change requests from two requesters and arbitrates between them.
- Switches clockgenerator's 3-bit sel only at a divider-aligned boundary, with the downstream clock gated, so the divided clock never glitches.
- Drives sel, a divider-counter clear and a clock-gate enable; tracks divider phase with an internal mirror counter.

Parameters:
- SETTLE_CYCLES, 4, cycles clock stays gated after sel update (1..15).
- RESET_SEL, 3'b001, sel_out value after reset (direct clock).
- CNT_W, 5, mirror phase counter width (supports up to divide-by-32).

Ports:
- clkin  input  1  clock; same clock that feeds clockgenerator.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 (high priority) level request.
- code0  input  3  requested sel code from requester 0.
- req1  input  1  requester 1 (low priority) level request.
- code1  input  3  requested sel code from requester 1.
- ack0  output  1  one-cycle completion pulse to requester 0.
- ack1  output  1  one-cycle completion pulse to requester 1.
- sel_out  output  3  drives clockgenerator sel.
- div_clr  output  1  one-cycle pulse clearing clockgenerator's divider counter.
- gate_en  output  1  downstream clock-gate enable; 0 = clkout masked.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
Sel codes:
- 000 off; 001 div1; 010 div2; 011 div4; 100 div8; 101 div16; 110 div32; 111 held high.
- All codes are legal.

Reset (rst high at a clkin edge):
- state=IDLE, sel_out=RESET_SEL, gate_en=1, div_clr=0, ack0=ack1=0, busy=0, phase counter=0.
- Reset mid-sequence abandons the switch and produces no ack. A requester still holding req is served afresh after reset.

Phase counter: CNT_W bits, increments every cycle, wraps 31->0, cleared in SWITCH.

Arbitration (IDLE only):
- req0 beats req1.
- Winner's code is latched into cur_code and the grant is latched.
- Codes and requests are not re-sampled until return to IDLE.
- A loser keeps req high and is served next.

FSM:
- IDLE: no req -> stay. Winner code == sel_out -> ACK next cycle (no gating, no div_clr). Otherwise -> ALIGN.
- ALIGN: wait until phase counter == all ones -> GATE. Maximum 32 cycles.
- GATE: gate_en=0 for one cycle -> SWITCH.
- SWITCH: sel_out<=cur_code, div_clr=1, counter<=0, gate_en=0 -> SETTLE.
- SETTLE: gate_en=0 for exactly SETTLE_CYCLES cycles -> ACK.
- ACK: gate_en=1; ack0 or ack1 high for this single cycle per the latched grant -> IDLE.

Latency:
- Same-code request: ack 2 edges after req is sampled (IDLE->ACK->pulse).
- Switch: ack = align wait + 1 (GATE) + 1 (SWITCH) + SETTLE_CYCLES + 1.

Handshake:
- req is level. A requester drops req the cycle after seeing ack; if still high in IDLE it is treated as a new request (same code -> fast ack).
- Withdrawing req mid-sequence has no effect; the sequence completes and ack still pulses.
- Changing code mid-sequence is ignored.
- Never both acks in one cycle. ack and busy: busy=1 during ACK, 0 in IDLE.
- gate_en is low from GATE through SETTLE inclusive; sel_out changes only while gate_en=0.

Optional Feature:
- CLKSEL_SWCNT_EN defined: adds output sw_count[7:0].
  - Increments in SWITCH and saturates at 255.
  - Same-code acks do not count.
  - Reset clears it to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- clksel_pkg holds: state encoding (IDLE, ALIGN, GATE, SWITCH, SETTLE, ACK), sel code constants (SEL_OFF..SEL_HIGH), default CNT_W.
- Sub-module clksel_arb: fixed-priority two-input arbiter with latched grant and code mux; enabled only in IDLE.
- FSM, phase counter and settle counter remain in clksel_sequencer.

Test Plan:
- Reset: rst high 2 cycles -> sel_out=001, gate_en=1, busy=0, no acks, no div_clr.
- Single switch: req0=1, code0=011 with phase counter at 5 -> 26 ALIGN cycles, gate_en=0 for 1+1+4 cycles, div_clr one pulse, sel_out=011 during SWITCH, ack0 pulse 1 cycle after SETTLE, gate_en=1 with ack.
- Same code: sel_out=011, req1=1, code1=011 -> ack1 2 edges later, gate_en never drops, no div_clr.
- Contention: req0 (code 101) and req1 (code 110) raised together -> requester 0 served first (sel_out=101, ack0); then requester 1 (sel_out=110, ack1); never simultaneous acks.
- Reset mid-sequence: rst asserted during SETTLE -> next cycle sel_out=001, gate_en=1, no ack; req still held -> full switch restarts.
- CLKSEL_SWCNT_EN build: 300 alternating 010/100 switches -> sw_count=255; same-code requests leave it unchanged.
